// File: rtl/vg_wrprecomp.sv
// rtl/vg_wrprecomp.sv - VG93 write precompensation and write-pulse shaper.
// Optional pulse counter on wr_pulses is built when VG_PRECOMP_STATS_EN is defined.
module vg_wrprecomp #(
    parameter int DLY_W = 5,
    parameter int NOM   = 14,
    parameter int PW    = 7,
    parameter int SYNC  = 2
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             vg_wd,
    input  logic             vg_sl,
    input  logic             vg_sr,
    input  logic             vg_tr43,
    input  logic             cfg_en,
    input  logic [DLY_W-1:0] cfg_outer,
    input  logic [DLY_W-1:0] cfg_inner,
    input  logic             ovr_clr,
    output logic             vg_wrd,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      wr_pulses
);

    localparam int XW = DLY_W + 2;
    localparam logic signed [XW-1:0] NOM_X  = XW'(NOM);
    localparam logic signed [XW-1:0] DMAX_X = XW'((1 << DLY_W) - 1);
    localparam logic [3:0]           PW_C   = 4'(PW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC-1:0]    wd_sync_q, sl_sync_q, sr_sync_q, tr_sync_q;
    logic               wd_edge_q;
    logic [DLY_W-1:0]   dcnt_q, dcnt_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic               vg_wrd_q, busy_q, overrun_q, overrun_d;
    logic               strobe;
    logic               sl_s, sr_s, tr_s;
    logic signed [XW-1:0] dsum;
    logic [DLY_W-1:0]   d_sel;

    // wd chain resets to ones so a strobe held high through reset is not seen as an edge
    always_ff @(posedge fclk) begin
        if (rst) begin
            wd_sync_q <= '1;
            wd_edge_q <= 1'b1;
            sl_sync_q <= '0;
            sr_sync_q <= '0;
            tr_sync_q <= '0;
        end else begin
            wd_sync_q <= {wd_sync_q[SYNC-2:0], vg_wd};
            wd_edge_q <= wd_sync_q[SYNC-1];
            sl_sync_q <= {sl_sync_q[SYNC-2:0], vg_sl};
            sr_sync_q <= {sr_sync_q[SYNC-2:0], vg_sr};
            tr_sync_q <= {tr_sync_q[SYNC-2:0], vg_tr43};
        end
    end

    assign strobe = wd_sync_q[SYNC-1] & ~wd_edge_q;
    assign sl_s   = sl_sync_q[SYNC-1];
    assign sr_s   = sr_sync_q[SYNC-1];
    assign tr_s   = tr_sync_q[SYNC-1];

    // Two guard bits so NOM plus the largest shift cannot wrap before clamping
    always_comb begin
        dsum = NOM_X;
        if (cfg_en) begin
            case ({sl_s, tr_s, sr_s})
                3'b100:  dsum = NOM_X - signed'({2'b00, cfg_outer});
                3'b001:  dsum = NOM_X + signed'({2'b00, cfg_outer});
                3'b110:  dsum = NOM_X - signed'({2'b00, cfg_inner});
                3'b011:  dsum = NOM_X + signed'({2'b00, cfg_inner});
                default: dsum = NOM_X;
            endcase
        end
        if (dsum < 0)
            d_sel = '0;
        else if (dsum > DMAX_X)
            d_sel = '1;
        else
            d_sel = dsum[DLY_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        wcnt_d    = wcnt_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    dcnt_d  = d_sel;
                    wcnt_d  = 4'd1;
                    state_d = (d_sel == '0) ? PULSE : DELAY;
                end
            end
            DELAY: begin
                dcnt_d = dcnt_q - DLY_W'(1);
                if (dcnt_q == DLY_W'(1)) begin
                    state_d = PULSE;
                    wcnt_d  = 4'd1;
                end
            end
            PULSE: begin
                if (wcnt_q == PW_C)
                    state_d = IDLE;
                else
                    wcnt_d = wcnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (strobe && state_q != IDLE)
            overrun_d = 1'b1;
        else if (ovr_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            wcnt_q    <= '0;
            vg_wrd_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            wcnt_q    <= wcnt_d;
            vg_wrd_q  <= (state_d == PULSE);
            busy_q    <= (state_d != IDLE);
            overrun_q <= overrun_d;
        end
    end

    assign vg_wrd  = vg_wrd_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

`ifdef VG_PRECOMP_STATS_EN
    logic [15:0] pulses_q, pulses_d;

    always_comb begin
        pulses_d = pulses_q;
        if (ovr_clr)
            pulses_d = 16'h0000;
        else if (state_q == PULSE && state_d == IDLE && pulses_q != 16'hFFFF)
            pulses_d = pulses_q + 16'd1;
    end

    always_ff @(posedge fclk) begin
        if (rst)
            pulses_q <= 16'h0000;
        else
            pulses_q <= pulses_d;
    end

    assign wr_pulses = pulses_q;
`else
    assign wr_pulses = 16'h0000;
`endif

endmodule

// File: tb/tb_vg_wrprecomp.sv
// tb/tb_vg_wrprecomp.sv - directed table-driven bench for vg_wrprecomp.
module tb_vg_wrprecomp;

    logic        fclk = 1'b0;
    logic        rst = 1'b1;
    logic        vg_wd = 1'b0, vg_sl = 1'b0, vg_sr = 1'b0, vg_tr43 = 1'b0;
    logic        cfg_en = 1'b1;
    logic [4:0]  cfg_outer = 5'd3, cfg_inner = 5'd7;
    logic        ovr_clr = 1'b0;
    logic        vg_wrd, busy, overrun;
    logic [15:0] wr_pulses;

    int n_checks = 0;
    int n_fail = 0;
    int exp_pulses = 0;

    vg_wrprecomp #(.DLY_W(5), .NOM(14), .PW(7), .SYNC(2)) dut (
        .fclk(fclk), .rst(rst), .vg_wd(vg_wd), .vg_sl(vg_sl), .vg_sr(vg_sr),
        .vg_tr43(vg_tr43), .cfg_en(cfg_en), .cfg_outer(cfg_outer),
        .cfg_inner(cfg_inner), .ovr_clr(ovr_clr), .vg_wrd(vg_wrd),
        .busy(busy), .overrun(overrun), .wr_pulses(wr_pulses)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic       sl, tr43, sr, en;
        logic [4:0] outer, inner;
        int         exp_d;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef VG_PRECOMP_STATS_EN
        chk(name, int'(wr_pulses), exp_pulses);
`else
        chk(name, int'(wr_pulses), 0);
`endif
    endtask

    task automatic pulse_done();
        if (exp_pulses < 65535) exp_pulses++;
    endtask

    // Raise vg_wd (sampled on the first following edge) and measure the shaped pulse
    task automatic run_pulse(input logic sl, input logic tr43, input logic sr,
                             input int exp_d, input string name);
        int first_hi;
        int width;
        vg_sl = sl; vg_tr43 = tr43; vg_sr = sr;
        repeat (3) @(posedge fclk);
        #1 vg_wd = 1'b1;
        first_hi = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge fclk);
            @(negedge fclk);
            if (vg_wrd) begin
                first_hi = k;
                break;
            end
        end
        chk({name, "_lat"}, first_hi, exp_d + 3);
        width = 0;
        if (first_hi > 0) begin
            width = 1;
            for (int k = 0; k < 40; k++) begin
                @(posedge fclk);
                @(negedge fclk);
                if (!vg_wrd) break;
                width++;
            end
            chk({name, "_busy_end"}, int'(busy), 0);
            pulse_done();
        end
        chk({name, "_width"}, width, 7);
        vg_wd = 1'b0;
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        chk_stats({name, "_stats"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_hi;
        int hi;
        int found;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd7, 14};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd7, 11};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd7, 17};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd7, 7};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd7, 21};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd7, 14};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd7, 14};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd7, 14};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd7, 14};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd20, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd20, 31};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd7, 14};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd7, 14};

        repeat (3) @(posedge fclk);
        @(negedge fclk);
        rst = 1'b0;
        @(negedge fclk);
        chk("rst_vg_wrd", int'(vg_wrd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_wr_pulses", int'(wr_pulses), 0);

        for (int i = 0; i < 13; i++) begin
            cfg_en    = vecs[i].en;
            cfg_outer = vecs[i].outer;
            cfg_inner = vecs[i].inner;
            run_pulse(vecs[i].sl, vecs[i].tr43, vecs[i].sr, vecs[i].exp_d,
                      $sformatf("vec%0d", i));
        end
        cfg_en = 1'b1; cfg_outer = 5'd3; cfg_inner = 5'd7;
        vg_sl = 1'b0; vg_tr43 = 1'b0; vg_sr = 1'b0;

        // Overrun: extra edges while delaying; second busy strobe coincides with ovr_clr
        repeat (3) @(posedge fclk);
        #1 vg_wd = 1'b1;
        first_hi = -1;
        hi = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge fclk);
            #1;
            if (k == 3) vg_wd = 1'b0;
            if (k == 5) vg_wd = 1'b1;
            if (k == 7) vg_wd = 1'b0;
            if (k == 9) vg_wd = 1'b1;
            ovr_clr = (k == 11);
            if (k == 11) exp_pulses = 0;
            @(negedge fclk);
            if (vg_wrd) begin
                hi++;
                if (first_hi < 0) first_hi = k;
            end
            if (k == 10) chk("ovr_set", int'(overrun), 1);
            if (k == 13) chk("ovr_set_beats_clr", int'(overrun), 1);
        end
        pulse_done();
        chk("ovr_first_lat", first_hi, 17);
        chk("ovr_hi_cycles", hi, 7);
        chk("ovr_busy_end", int'(busy), 0);
        chk_stats("ovr_stats");

        vg_wd = 1'b0;
        @(posedge fclk);
        #1 ovr_clr = 1'b1;
        exp_pulses = 0;
        @(posedge fclk);
        #1 ovr_clr = 1'b0;
        @(negedge fclk);
        chk("ovr_cleared", int'(overrun), 0);
        chk_stats("ovr_clr_stats");

        // Reset in the middle of PULSE with vg_wd held high
        repeat (3) @(posedge fclk);
        #1 vg_wd = 1'b1;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge fclk);
            @(negedge fclk);
            if (vg_wrd) begin
                found = 1;
                break;
            end
        end
        chk("rstmid_reached_pulse", found, 1);
        @(posedge fclk);
        @(negedge fclk);
        rst = 1'b1;
        @(posedge fclk);
        @(negedge fclk);
        rst = 1'b0;
        exp_pulses = 0;
        chk("rstmid_vg_wrd", int'(vg_wrd), 0);
        chk("rstmid_busy", int'(busy), 0);
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge fclk);
            @(negedge fclk);
            if (vg_wrd || busy) hi++;
        end
        chk("rstmid_no_strobe", hi, 0);
        chk_stats("rstmid_stats");
        vg_wd = 1'b0;
        run_pulse(1'b0, 1'b0, 1'b0, 14, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
